// File: rtl/chan_serializer_pkg.sv
// ============================================================================
//  Module      : chan_serializer_pkg
//  Description : Shared constants and FSM encodings for the output-channel
//                router and the channel serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chan_serializer_pkg;

   // Default bus geometry shared with the output-channel router
   localparam int W_CHAN_DEF = 16;
   localparam int W_SEL_DEF  = 4;
   localparam int N_CHAN_DEF = 8;

   // Serializer FSM encodings
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } ser_state_t;

endpackage : chan_serializer_pkg

`default_nettype wire

// File: rtl/chan_serializer_if.sv
// ============================================================================
//  Module      : chan_serializer_if
//  Description : Sample stream from the serializer to the DAC controller,
//                valid/ready handshake with channel tag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface chan_serializer_if
   import chan_serializer_pkg::*;
#(
   parameter int W_CHAN = W_CHAN_DEF,
   parameter int W_SEL  = W_SEL_DEF
) ();

   logic [W_CHAN-1:0] data_out;
   logic [W_SEL-1:0]  chan_out;
   logic              data_valid_out;
   logic              dac_ready_in;

   // Serializer side: offers samples
   modport master (
      output data_out,
      output chan_out,
      output data_valid_out,
      input  dac_ready_in
   );

   // DAC controller side: accepts samples
   modport slave (
      input  data_out,
      input  chan_out,
      input  data_valid_out,
      output dac_ready_in
   );

endinterface : chan_serializer_if

`default_nettype wire

// File: rtl/chan_serializer_rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational rotate-priority encoder. Returns the first
//                requesting index at or after ptr, wrapping N_CHAN-1 -> 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
   import chan_serializer_pkg::*;
#(
   parameter int N_CHAN = N_CHAN_DEF,
   parameter int W_SEL  = W_SEL_DEF
) (
   input  logic [N_CHAN-1:0] req,
   input  logic [W_SEL-1:0]  ptr,
   output logic [W_SEL-1:0]  gnt_idx,
   output logic              gnt_any
);

   // Scan N_CHAN positions starting at ptr; the first hit wins
   always_comb begin
      int idx;
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = 0;
      for (int i = 0; i < N_CHAN; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N_CHAN) begin
            idx = idx - N_CHAN;
         end
         if (!gnt_any && req[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = W_SEL'(idx);
         end
      end
   end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/chan_serializer.sv
// ============================================================================
//  Module      : chan_serializer
//  Description : Buffers one sample per channel from the packed router bus
//                and streams them, tagged with channel index, to the DAC
//                controller. Round-robin among pending channels; sticky
//                per-channel overrun flags record samples replaced before
//                they could be sent.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chan_serializer
   import chan_serializer_pkg::*;
#(
   parameter int W_CHAN = W_CHAN_DEF,
   parameter int W_SEL  = W_SEL_DEF,
   parameter int N_CHAN = N_CHAN_DEF
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic [W_CHAN*N_CHAN-1:0] data_packed_in,
   input  logic [N_CHAN-1:0]        data_valid_in,
   input  logic [N_CHAN-1:0]        output_active_in,
   input  logic                     overrun_clr_in,
   chan_serializer_if.master        dac,
   output logic [N_CHAN-1:0]        overrun_out
);

   // Per-channel sample slices of the packed bus
   logic [W_CHAN-1:0] sample [N_CHAN];

   // Channel buffers and bookkeeping
   logic [W_CHAN-1:0] hold_q [N_CHAN];
   logic [W_CHAN-1:0] hold_d [N_CHAN];
   logic [N_CHAN-1:0] pending_q, pending_d;
   logic [N_CHAN-1:0] overrun_q, overrun_d;
   logic [W_SEL-1:0]  ptr_q, ptr_d;

   // Output stage
   ser_state_t        state_q, state_d;
   logic [W_CHAN-1:0] data_q, data_d;
   logic [W_SEL-1:0]  chan_q, chan_d;
   logic              valid_q, valid_d;

   // Arbitration
   logic [N_CHAN-1:0] capture;
   logic [N_CHAN-1:0] req;
   logic [N_CHAN-1:0] grant_oh;
   logic [N_CHAN-1:0] lost;
   logic [W_SEL-1:0]  gnt_idx;
   logic              gnt_any;
   logic              grant_fire;
   logic [W_CHAN-1:0] grant_data;

   generate
      for (genvar k = 0; k < N_CHAN; k++) begin : g_slice
         assign sample[k] = data_packed_in[k*W_CHAN +: W_CHAN];
      end
   endgenerate

   assign capture = data_valid_in & output_active_in;
   // A channel being deactivated this cycle must not be granted its stale sample
   assign req     = pending_q & output_active_in;

   rr_arbiter #(
      .N_CHAN (N_CHAN),
      .W_SEL  (W_SEL)
   ) u_arb (
      .req     (req),
      .ptr     (ptr_q),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   assign grant_fire = (state_q == ST_IDLE) && gnt_any;

   // Capture, pending and overrun bookkeeping per channel
   always_comb begin
      grant_data = '0;
      grant_oh   = '0;
      lost       = '0;
      pending_d  = pending_q;
      for (int k = 0; k < N_CHAN; k++) begin
         hold_d[k]   = hold_q[k];
         grant_oh[k] = grant_fire && (gnt_idx == W_SEL'(k));
         if (gnt_idx == W_SEL'(k)) begin
            grant_data = hold_q[k];
         end
         // Grant reads the old buffer value, so a same-cycle capture is not a loss
         lost[k] = capture[k] && pending_q[k] && !grant_oh[k];
         if (capture[k]) begin
            hold_d[k] = sample[k];
         end
         if (!output_active_in[k]) begin
            pending_d[k] = 1'b0;
         end else if (capture[k]) begin
            pending_d[k] = 1'b1;
         end else if (grant_oh[k]) begin
            pending_d[k] = 1'b0;
         end
      end
      // A new overrun beats the clear on its own channel
      if (overrun_clr_in) begin
         overrun_d = lost;
      end else begin
         overrun_d = overrun_q | lost;
      end
   end

   // Next-state and output-register logic for the IDLE/SEND handshake FSM
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      chan_d  = chan_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_IDLE: begin
            valid_d = 1'b0;
            if (gnt_any) begin
               data_d  = grant_data;
               chan_d  = gnt_idx;
               valid_d = 1'b1;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (valid_q && dac.dac_ready_in) begin
               valid_d = 1'b0;
               ptr_d   = (chan_q == W_SEL'(N_CHAN-1)) ? '0 : chan_q + W_SEL'(1);
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Buffers, flags, pointer and output registers
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int k = 0; k < N_CHAN; k++) begin
            hold_q[k] <= '0;
         end
         pending_q <= '0;
         overrun_q <= '0;
         ptr_q     <= '0;
         data_q    <= '0;
         chan_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         for (int k = 0; k < N_CHAN; k++) begin
            hold_q[k] <= hold_d[k];
         end
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         ptr_q     <= ptr_d;
         data_q    <= data_d;
         chan_q    <= chan_d;
         valid_q   <= valid_d;
      end
   end

   assign dac.data_out       = data_q;
   assign dac.chan_out       = chan_q;
   assign dac.data_valid_out = valid_q;
   assign overrun_out        = overrun_q;

endmodule : chan_serializer

`default_nettype wire
